// File: rtl/axi_wr_sched.sv
// Two-master AXI write-path scheduler: AW arbitration, in-order W steering and B routing by ID bit.
// Define WR_SCHED_RR_EN for round-robin AW arbitration; otherwise m0 has fixed priority.
module axi_wr_sched #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int WQ_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ID_WIDTH-1:0]     m0_awid,
    input  logic [ADDR_WIDTH-1:0]   m0_awaddr,
    input  logic [7:0]              m0_awlen,
    input  logic                    m0_awvalid,
    output logic                    m0_awready,
    input  logic [DATA_WIDTH-1:0]   m0_wdata,
    input  logic [DATA_WIDTH/8-1:0] m0_wstrb,
    input  logic                    m0_wlast,
    input  logic                    m0_wvalid,
    output logic                    m0_wready,
    output logic [ID_WIDTH-1:0]     m0_bid,
    output logic [1:0]              m0_bresp,
    output logic                    m0_bvalid,
    input  logic                    m0_bready,
    input  logic [ID_WIDTH-1:0]     m1_awid,
    input  logic [ADDR_WIDTH-1:0]   m1_awaddr,
    input  logic [7:0]              m1_awlen,
    input  logic                    m1_awvalid,
    output logic                    m1_awready,
    input  logic [DATA_WIDTH-1:0]   m1_wdata,
    input  logic [DATA_WIDTH/8-1:0] m1_wstrb,
    input  logic                    m1_wlast,
    input  logic                    m1_wvalid,
    output logic                    m1_wready,
    output logic [ID_WIDTH-1:0]     m1_bid,
    output logic [1:0]              m1_bresp,
    output logic                    m1_bvalid,
    input  logic                    m1_bready,
    output logic [ID_WIDTH:0]       s_awid,
    output logic [ADDR_WIDTH-1:0]   s_awaddr,
    output logic [7:0]              s_awlen,
    output logic                    s_awvalid,
    input  logic                    s_awready,
    output logic [DATA_WIDTH-1:0]   s_wdata,
    output logic [DATA_WIDTH/8-1:0] s_wstrb,
    output logic                    s_wlast,
    output logic                    s_wvalid,
    input  logic                    s_wready,
    input  logic [ID_WIDTH:0]       s_bid,
    input  logic [1:0]              s_bresp,
    input  logic                    s_bvalid,
    output logic                    s_bready
);
    localparam int PTR_W = $clog2(WQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WQ_DEPTH-1:0] wq_q, wq_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                aw_lock_q, aw_lock_d, lock_idx_q, lock_idx_d;
`ifdef WR_SCHED_RR_EN
    logic                rr_last_q, rr_last_d;
`endif
    logic arb_idx, grant_idx, grant_vld, wq_full, wq_empty, head_idx, w_en, aw_hs, w_pop;

    assign wq_full  = (count_q == CNT_W'(WQ_DEPTH));
    assign wq_empty = (count_q == '0);

    always_comb begin
        arb_idx = 1'b0;
        if (m0_awvalid && m1_awvalid) begin
`ifdef WR_SCHED_RR_EN
            arb_idx = ~rr_last_q;
`else
            arb_idx = 1'b0;
`endif
        end else if (m1_awvalid) begin
            arb_idx = 1'b1;
        end
        // A stalled AW keeps its grant so the presented payload cannot switch masters.
        grant_idx = aw_lock_q ? lock_idx_q : arb_idx;
        grant_vld = !rst && !wq_full && (grant_idx ? m1_awvalid : m0_awvalid);
    end

    assign s_awvalid  = grant_vld;
    assign s_awid     = {grant_idx, (grant_idx ? m1_awid : m0_awid)};
    assign s_awaddr   = grant_idx ? m1_awaddr : m0_awaddr;
    assign s_awlen    = grant_idx ? m1_awlen : m0_awlen;
    assign m0_awready = grant_vld && !grant_idx && s_awready;
    assign m1_awready = grant_vld && grant_idx && s_awready;
    assign aw_hs      = s_awvalid && s_awready;

    assign head_idx  = wq_q[rd_ptr_q];
    assign w_en      = !rst && !wq_empty;
    assign s_wvalid  = w_en && (head_idx ? m1_wvalid : m0_wvalid);
    assign s_wdata   = head_idx ? m1_wdata : m0_wdata;
    assign s_wstrb   = head_idx ? m1_wstrb : m0_wstrb;
    assign s_wlast   = head_idx ? m1_wlast : m0_wlast;
    assign m0_wready = w_en && !head_idx && s_wready;
    assign m1_wready = w_en && head_idx && s_wready;
    assign w_pop     = s_wvalid && s_wready && s_wlast;

    assign m0_bid    = s_bid[ID_WIDTH-1:0];
    assign m1_bid    = s_bid[ID_WIDTH-1:0];
    assign m0_bresp  = s_bresp;
    assign m1_bresp  = s_bresp;
    assign m0_bvalid = !rst && s_bvalid && !s_bid[ID_WIDTH];
    assign m1_bvalid = !rst && s_bvalid && s_bid[ID_WIDTH];
    assign s_bready  = !rst && (s_bid[ID_WIDTH] ? m1_bready : m0_bready);

    always_comb begin
        wq_d       = wq_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        aw_lock_d  = aw_lock_q;
        lock_idx_d = lock_idx_q;
`ifdef WR_SCHED_RR_EN
        rr_last_d  = rr_last_q;
`endif
        if (aw_hs) begin
            wq_d[wr_ptr_q] = grant_idx;
            wr_ptr_d       = wr_ptr_q + PTR_W'(1);
            aw_lock_d      = 1'b0;
`ifdef WR_SCHED_RR_EN
            rr_last_d      = grant_idx;
`endif
        end else if (s_awvalid) begin
            aw_lock_d  = 1'b1;
            lock_idx_d = grant_idx;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({aw_hs, w_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wq_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            aw_lock_q  <= 1'b0;
            lock_idx_q <= 1'b0;
`ifdef WR_SCHED_RR_EN
            rr_last_q  <= 1'b1;
`endif
        end else begin
            wq_q       <= wq_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            aw_lock_q  <= aw_lock_d;
            lock_idx_q <= lock_idx_d;
`ifdef WR_SCHED_RR_EN
            rr_last_q  <= rr_last_d;
`endif
        end
    end
endmodule

// File: tb/tb_axi_wr_sched.sv
// Directed bench for axi_wr_sched: AW arbitration/lock, queue-full, W ordering, B routing, reset.
module tb_axi_wr_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  m0_awid, m1_awid, m0_bid, m1_bid;
    logic [31:0] m0_awaddr, m1_awaddr, s_awaddr;
    logic [7:0]  m0_awlen, m1_awlen, s_awlen;
    logic        m0_awvalid, m0_awready, m1_awvalid, m1_awready;
    logic [31:0] m0_wdata, m1_wdata, s_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb, s_wstrb;
    logic        m0_wlast, m0_wvalid, m0_wready, m1_wlast, m1_wvalid, m1_wready;
    logic [1:0]  m0_bresp, m1_bresp, s_bresp;
    logic        m0_bvalid, m0_bready, m1_bvalid, m1_bready;
    logic [4:0]  s_awid, s_bid;
    logic        s_awvalid, s_awready, s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    always #5 clk = ~clk;

    axi_wr_sched #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .WQ_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .m0_awid(m0_awid), .m0_awaddr(m0_awaddr), .m0_awlen(m0_awlen),
        .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wlast(m0_wlast),
        .m0_wvalid(m0_wvalid), .m0_wready(m0_wready),
        .m0_bid(m0_bid), .m0_bresp(m0_bresp), .m0_bvalid(m0_bvalid), .m0_bready(m0_bready),
        .m1_awid(m1_awid), .m1_awaddr(m1_awaddr), .m1_awlen(m1_awlen),
        .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wlast(m1_wlast),
        .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
        .m1_bid(m1_bid), .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
        .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
        .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_awid = '0; m0_awaddr = '0; m0_awlen = '0; m0_awvalid = 1'b0;
        m1_awid = '0; m1_awaddr = '0; m1_awlen = '0; m1_awvalid = 1'b0;
        m0_wdata = '0; m0_wstrb = '1; m0_wlast = 1'b0; m0_wvalid = 1'b0; m0_bready = 1'b0;
        m1_wdata = '0; m1_wstrb = '1; m1_wlast = 1'b0; m1_wvalid = 1'b0; m1_bready = 1'b0;
        s_awready = 1'b0; s_wready = 1'b0; s_bid = '0; s_bresp = '0; s_bvalid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_win [3];
        logic exp_head [3];

        // Reset gating: requests held high during reset must not leak through.
        rst = 1'b1;
        clear_inputs();
        m0_awvalid = 1'b1; m0_wvalid = 1'b1; s_awready = 1'b1; s_wready = 1'b1;
        s_bvalid = 1'b1; s_bid = 5'h03;
        nxt();
        check("rst_s_awvalid", s_awvalid, 1'b0);
        check("rst_s_wvalid", s_wvalid, 1'b0);
        check("rst_m0_awready", m0_awready, 1'b0);
        check("rst_m0_bvalid", m0_bvalid, 1'b0);
        do_reset();

        // Test 1: single m0 burst of 4 beats, then B routing.
        m0_awvalid = 1'b1; m0_awid = 4'h3; m0_awlen = 8'd3; m0_awaddr = 32'h1000;
        m0_wvalid = 1'b1; m0_wdata = 32'h100; s_awready = 1'b1; s_wready = 1'b1;
        #1;
        check("t1_s_awvalid", s_awvalid, 1'b1);
        check("t1_s_awid", s_awid, 5'h03);
        check("t1_s_awaddr", s_awaddr, 32'h1000);
        check("t1_m0_awready", m0_awready, 1'b1);
        check("t1_m1_awready", m1_awready, 1'b0);
        check("t1_w_held", s_wvalid, 1'b0);
        check("t1_m0_wready_held", m0_wready, 1'b0);
        nxt();
        m0_awvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m0_wdata = 32'h100 + i;
            m0_wlast = (i == 3);
            #1;
            check("t1_s_wvalid", s_wvalid, 1'b1);
            check("t1_s_wdata", s_wdata, 32'h100 + i);
            check("t1_s_wlast", s_wlast, (i == 3));
            check("t1_m0_wready", m0_wready, 1'b1);
            nxt();
        end
        m0_wlast = 1'b0;
        #1;
        check("t1_empty_wvalid", s_wvalid, 1'b0);
        check("t1_empty_wready", m0_wready, 1'b0);
        m0_wvalid = 1'b0;
        s_bvalid = 1'b1; s_bid = 5'h03; s_bresp = 2'b00; m0_bready = 1'b1;
        #1;
        check("t1_m0_bvalid", m0_bvalid, 1'b1);
        check("t1_m1_bvalid", m1_bvalid, 1'b0);
        check("t1_m0_bid", m0_bid, 4'h3);
        check("t1_s_bready", s_bready, 1'b1);
        s_bid = 5'h12; s_bresp = 2'b10; m1_bready = 1'b0;
        #1;
        check("t1_m1_bvalid", m1_bvalid, 1'b1);
        check("t1_m0_bvalid_off", m0_bvalid, 1'b0);
        check("t1_m1_bid", m1_bid, 4'h2);
        check("t1_m1_bresp", m1_bresp, 2'b10);
        check("t1_s_bready_m1", s_bready, 1'b0);

        // Test 2: contended AW from reset.
        do_reset();
`ifdef WR_SCHED_RR_EN
        exp_win = '{1'b0, 1'b1, 1'b0};
`else
        exp_win = '{1'b0, 1'b0, 1'b0};
`endif
        m0_awvalid = 1'b1; m0_awid = 4'h1; m1_awvalid = 1'b1; m1_awid = 4'h2; s_awready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t2_s_awid", s_awid, exp_win[i] ? 5'h12 : 5'h01);
            check("t2_m0_awready", m0_awready, !exp_win[i]);
            check("t2_m1_awready", m1_awready, exp_win[i]);
            nxt();
        end

        // Test 3: locked grant on m1 while s_awready is low.
        do_reset();
        m1_awvalid = 1'b1; m1_awid = 4'h5;
        #1;
        check("t3_s_awid0", s_awid, 5'h15);
        nxt();
        m0_awvalid = 1'b1; m0_awid = 4'h6;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("t3_s_awid_lock", s_awid, 5'h15);
            check("t3_m0_awready_lock", m0_awready, 1'b0);
            nxt();
        end
        s_awready = 1'b1;
        #1;
        check("t3_s_awid_hs", s_awid, 5'h15);
        check("t3_m1_awready_hs", m1_awready, 1'b1);
        check("t3_m0_awready_hs", m0_awready, 1'b0);
        nxt();
        m1_awvalid = 1'b0;
        #1;
        check("t3_s_awid_m0", s_awid, 5'h06);
        check("t3_m0_awready", m0_awready, 1'b1);
        nxt();
        m0_awvalid = 1'b0;

        // Test 5: queue holds m1 then m0; m1 beats must drain first.
        m1_wvalid = 1'b1; m1_wdata = 32'hB0; m0_wvalid = 1'b1; m0_wdata = 32'hA0; m0_wlast = 1'b1;
        s_wready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            m1_wlast = (i == 1);
            m1_wdata = 32'hB0 + i;
            #1;
            check("t5_s_wdata_m1", s_wdata, 32'hB0 + i);
            check("t5_m1_wready", m1_wready, 1'b1);
            check("t5_m0_wready", m0_wready, 1'b0);
            nxt();
        end
        #1;
        check("t5_s_wdata_m0", s_wdata, 32'hA0);
        check("t5_m0_wready_after", m0_wready, 1'b1);
        check("t5_m1_wready_after", m1_wready, 1'b0);
        nxt();
        check("t5_empty", s_wvalid, 1'b0);

        // Test 4: fill the queue, hold a 5th AW until the first pop.
        do_reset();
        s_awready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            m0_awvalid = (i % 2 == 0); m1_awvalid = (i % 2 == 1);
            m0_awid = 4'(i + 1); m1_awid = 4'(i + 1);
            #1;
            check("t4_fill_awready", (i % 2 == 0) ? m0_awready : m1_awready, 1'b1);
            nxt();
        end
        m1_awvalid = 1'b0;
        m0_awvalid = 1'b1; m0_awid = 4'h7;
        m0_wvalid = 1'b1; m0_wlast = 1'b1; m0_wdata = 32'hA0;
        m1_wvalid = 1'b1; m1_wlast = 1'b1; m1_wdata = 32'hB1;
        #1;
        check("t4_full_awvalid", s_awvalid, 1'b0);
        check("t4_full_m0_awready", m0_awready, 1'b0);
        check("t4_head_wdata", s_wdata, 32'hA0);
        check("t4_head_wvalid", s_wvalid, 1'b1);
        check("t4_stall_wready", m0_wready, 1'b0);
        nxt();
        check("t4_full_awvalid2", s_awvalid, 1'b0);
        s_wready = 1'b1;
        #1;
        check("t4_pop_cycle_awvalid", s_awvalid, 1'b0);
        check("t4_pop_m0_wready", m0_wready, 1'b1);
        nxt();
        check("t4_push_awvalid", s_awvalid, 1'b1);
        check("t4_push_awid", s_awid, 5'h07);
        check("t4_push_m0_awready", m0_awready, 1'b1);
        check("t4_head1_wdata", s_wdata, 32'hB1);
        check("t4_head1_m1_wready", m1_wready, 1'b1);
        nxt();
        m0_awvalid = 1'b0;
        exp_head = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t4_order_wdata", s_wdata, exp_head[i] ? 32'hB1 : 32'hA0);
            check("t4_order_wvalid", s_wvalid, 1'b1);
            nxt();
        end
        check("t4_drained", s_wvalid, 1'b0);

        // Test 6: reset after 2 of 4 beats drops the burst.
        do_reset();
        m0_awvalid = 1'b1; m0_awid = 4'h3; m0_awlen = 8'd3; s_awready = 1'b1;
        nxt();
        m0_awvalid = 1'b0; m0_wvalid = 1'b1; s_wready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("t6_beat_wvalid", s_wvalid, 1'b1);
            nxt();
        end
        rst = 1'b1;
        #1;
        check("t6_rst_wvalid", s_wvalid, 1'b0);
        nxt();
        rst = 1'b0;
        #1;
        check("t6_post_wvalid", s_wvalid, 1'b0);
        check("t6_post_m0_wready", m0_wready, 1'b0);
        m0_awvalid = 1'b1; m0_awid = 4'h9; m1_awvalid = 1'b1; m1_awid = 4'hA;
        s_bvalid = 1'b1; s_bid = 5'h1A; m1_bready = 1'b1;
        #1;
        check("t6_awid_m0_first", s_awid, 5'h09);
        check("t6_m0_awready", m0_awready, 1'b1);
        check("t6_m1_awready", m1_awready, 1'b0);
        check("t6_b_route_m1", m1_bvalid, 1'b1);
        check("t6_b_s_bready", s_bready, 1'b1);
        nxt();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/axi_wr_sched.md
Name: axi_wr_sched

Overview:
Write-path scheduler that shares one AXI slave write port (AW, W, B) between two masters. It arbitrates AW requests and records the granted master in a write-order queue. It steers W beats from the queue-head master until WLAST, and routes B responses back by an ID bit it prepends. It completes the write path alongside the existing AW/AR arbiter, including the W-channel beat tracking and BID routing.

Parameters:
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, write data width; WSTRB width = DATA_WIDTH/8
ID_WIDTH, 4, master-side ID width; slave-side ID width = ID_WIDTH+1
WQ_DEPTH, 4, write-order queue entries (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
mN_awid/awaddr/awlen  in  ID_WIDTH/ADDR_WIDTH/8  AW payload, master N (N=0,1)
mN_awvalid in 1; mN_awready out 1  AW handshake, master N
mN_wdata/wstrb/wlast  in  DATA_WIDTH/DATA_WIDTH/8/1  W payload, master N
mN_wvalid in 1; mN_wready out 1  W handshake, master N
mN_bid/bresp  out  ID_WIDTH/2  B payload, master N
mN_bvalid out 1; mN_bready in 1  B handshake, master N
s_awid  out  ID_WIDTH+1  {grant_idx, mN_awid}
s_awaddr/awlen  out  ADDR_WIDTH/8  muxed AW payload
s_awvalid out 1; s_awready in 1
s_wdata/wstrb/wlast  out  DATA_WIDTH/DATA_WIDTH/8/1  muxed W payload
s_wvalid out 1; s_wready in 1
s_bid  in  ID_WIDTH+1; s_bresp in 2; s_bvalid in 1; s_bready out 1

Behaviour:
- Reset: queue empty (count=0, rd/wr ptr=0), aw_lock=0, rr_last=1 (m0 wins first), wq_busy=0. While rst=1: s_awvalid=0, s_wvalid=0, all mN_awready/mN_wready/mN_bvalid=0.
- AW grant is combinational, 0-cycle latency. It is chosen only when aw_lock=0. If exactly one master is valid, that master wins. If both are valid, the master != rr_last wins.
- aw_lock: set when s_awvalid && !s_awready and grant is stable. The grant is frozen until the handshake; AXI requires a valid AW to stay asserted. The lock clears on the handshake.
- AW handshake (s_awvalid && s_awready): push grant_idx into the queue, set rr_last=grant_idx, and forward mN_awready only to the granted master.
- Queue full (count==WQ_DEPTH): s_awvalid=0 and both awready=0. Fullness comes from the registered count; a same-cycle pop does not admit a push.
- W: the queue head selects the master once the queue is non-empty. s_wvalid = head master's wvalid, and only the head master sees wready=s_wready.
- On a W handshake with wlast=1, pop the queue. The next burst's beats may pass the following cycle, so there is no bubble requirement beyond one cycle.
- With the queue empty, s_wvalid=0 and both wready=0. W beats issued before their AW is accepted are held off; an AW push takes effect one cycle before its W is forwarded.
- Simultaneous push and pop (not full): count is unchanged and both pointers advance. Pointers wrap mod WQ_DEPTH.
- B: s_bid[ID_WIDTH] selects the master. mN_bid = s_bid[ID_WIDTH-1:0] and mN_bresp = s_bresp for both. Only the selected master sees bvalid. s_bready = selected master's bready. B is purely combinational and stateless.
- A reset mid-burst drops queue contents and the lock. Outstanding B responses returned after reset are still routed by ID bit.

Optional Feature:
Macro WR_SCHED_RR_EN.
- Defined: round-robin AW arbitration as above.
- Undefined: fixed priority, m0 always wins when valid. rr_last is not implemented; aw_lock still applies.

Test Plan:
1. After reset, m0 sends AW id=3 len=3 followed by 4 W beats -> s_awid=5'h03. Exactly 4 s_w handshakes occur, the last with s_wlast=1, and the queue returns to empty. A BID of 5'h03 gives m0_bvalid=1, m1_bvalid=0, m0_bid=3.
2. m0 and m1 assert AWVALID in the same cycle, with s_awready high -> RR_EN: m0 is accepted first, then m1 next cycle, then alternation. Without RR_EN, m0 wins on every contended cycle.
3. m1 has AW pending with s_awready=0 for 3 cycles, then m0 raises awvalid -> grant stays on m1 until its handshake, and m0_awready stays 0 throughout.
4. Four AWs are accepted (len=0), W is stalled, and a 5th AW is pending -> s_awvalid=0 until the first wlast handshake pops the queue. W is forwarded in AW order.
5. AWs are accepted as m1 then m0, and both masters hold wvalid -> all m1 beats through wlast pass first, and m0_wready=0 until the m1 pop.
6. Reset is asserted mid-burst after 2 of 4 beats -> the next cycle has queue empty, s_wvalid=0, and the next AW is accepted by m0 first.
